// File: rtl/jk_timer_pkg.sv
// Shared definitions for the JK timer controller: FSM state encoding and count direction.
package jk_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset (Q resets to 0).
// Ports: clk, rst, j, k (drive inputs), q (state).
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // j&~q sets / toggles, ~k&q holds a one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= (j & ~q) | (~k & q);
  end

endmodule

// File: rtl/jk_timer_ctrl.sv
// Window timer built on a WIDTH-bit synchronous JK-flip-flop counter.
// Sequences load/count/hold drive vectors through IDLE/LOAD/RUN/DONE with
// one-shot or auto-reload operation.
// Ports: clk, rst (async, active-high); start/stop handshake; dir, auto_reload,
// limit config (captured on accepted start); busy/done status; tc terminal
// count flag; count (flip-flop Q vector); j/k drive vectors for debug.
module jk_timer_ctrl
  import jk_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  state_t           state, state_nxt;
  logic             cfg_capture;
  logic             dir_q;
  logic             ar_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] sv, ev;
  logic [WIDTH-1:0] up_drv, dn_drv;

  // Counter datapath: one JK flip-flop per bit
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ff
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (q[gi])
    );
  end

  assign count = q;

  // Window endpoints from the captured configuration
  assign sv = (dir_q == DIR_DOWN) ? limit_q : '0;
  assign ev = (dir_q == DIR_DOWN) ? '0 : limit_q;

  // Toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    up_drv   = '0;
    dn_drv   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_drv[i] = all_one;
      dn_drv[i] = all_zero;
      all_one   = all_one & q[i];
      all_zero  = all_zero & ~q[i];
    end
  end

  // State register and configuration capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      ar_q    <= 1'b0;
      limit_q <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_capture) begin
        dir_q   <= dir;
        ar_q    <= auto_reload;
        limit_q <= limit;
      end
    end
  end

  // Next-state, drive vectors and terminal-count flag; stop outranks tc in RUN
  always_comb begin
    state_nxt   = state;
    cfg_capture = 1'b0;
    tc          = 1'b0;
    j           = '0;
    k           = '0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          cfg_capture = 1'b1;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          j         = sv;
          k         = ~sv;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (count == ev) begin
          tc = 1'b1;
          if (ar_q) begin
            j = sv;
            k = ~sv;
          end else begin
            state_nxt = DONE;
          end
        end else if (dir_q == DIR_UP) begin
          j = up_drv;
          k = up_drv;
        end else begin
          j = dn_drv;
          k = dn_drv;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status decoded directly from the state register
  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_jk_timer_ctrl.sv
// Directed table-driven bench for jk_timer_ctrl (WIDTH=3), plus a hand-written
// asynchronous-reset-mid-run sequence.
module tb_jk_timer_ctrl;

  localparam int unsigned W = 3;

  typedef struct {
    logic         start;
    logic         stop;
    logic         dir;
    logic         ar;
    logic [W-1:0] lim;
    logic         busy;
    logic         done;
    logic         tc;
    logic [W-1:0] cnt;
    logic [W-1:0] j;
    logic [W-1:0] k;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, dir, auto_reload;
  logic [W-1:0] limit;
  logic         busy, done, tc;
  logic [W-1:0] count, j, k;

  vec_t tbl[80];
  int   nvec   = 0;
  int   passed = 0;
  int   total  = 0;

  jk_timer_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .auto_reload (auto_reload),
    .limit       (limit),
    .busy        (busy),
    .done        (done),
    .tc          (tc),
    .count       (count),
    .j           (j),
    .k           (k)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, input logic sp, input logic d, input logic a,
                     input logic [W-1:0] l, input logic b, input logic dn,
                     input logic t, input logic [W-1:0] c, input logic [W-1:0] jj,
                     input logic [W-1:0] kk);
    tbl[nvec] = '{s, sp, d, a, l, b, dn, t, c, jj, kk};
    nvec++;
  endtask

  // Up-count drive for a given count value: bit i toggles when lower bits are all 1
  function automatic logic [W-1:0] up_jk(input logic [W-1:0] c);
    return {c[0] & c[1], c[0], 1'b1};
  endfunction

  task automatic chk(input string nm, input logic b, input logic dn, input logic t,
                     input logic [W-1:0] c, input logic [W-1:0] jj, input logic [W-1:0] kk);
    logic [3*W+2:0] act, exp;
    act = {busy, done, tc, count, j, k};
    exp = {b, dn, t, c, jj, kk};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got busy=%b done=%b tc=%b count=%0d j=%b k=%b, want busy=%b done=%b tc=%b count=%0d j=%b k=%b",
                  nm, busy, done, tc, count, j, k, b, dn, t, c, jj, kk);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; dir = 0; auto_reload = 0; limit = '0;

    // One-shot up, limit 5; config wiggled mid-run must be ignored
    add(1,0,0,0,5, 0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,0,7);
    add(0,0,0,0,0, 1,0,0,0,1,1);
    add(0,0,0,0,0, 1,0,0,1,3,3);
    add(1,0,1,1,2, 1,0,0,2,1,1);
    add(0,0,0,0,0, 1,0,0,3,7,7);
    add(0,0,0,0,0, 1,0,0,4,1,1);
    add(0,0,0,0,0, 1,0,1,5,0,0);
    add(0,0,0,0,0, 0,1,0,5,0,0);
    add(0,0,0,0,0, 0,0,0,5,0,0);
    // One-shot down, limit 6
    add(1,0,1,0,6, 0,0,0,5,0,0);
    add(0,0,0,0,0, 1,0,0,5,6,1);
    add(0,0,0,0,0, 1,0,0,6,3,3);
    add(0,0,0,0,0, 1,0,0,5,1,1);
    add(0,0,0,0,0, 1,0,0,4,7,7);
    add(0,0,0,0,0, 1,0,0,3,1,1);
    add(0,0,0,0,0, 1,0,0,2,3,3);
    add(0,0,0,0,0, 1,0,0,1,1,1);
    add(0,0,0,0,0, 1,0,1,0,0,0);
    add(0,0,0,0,0, 0,1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // Auto-reload up, limit 2; start while running ignored; stop freezes count
    add(1,0,0,1,2, 0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,0,7);
    add(0,0,0,0,0, 1,0,0,0,1,1);
    add(0,0,0,0,0, 1,0,0,1,3,3);
    add(0,0,0,0,0, 1,0,1,2,0,7);
    add(0,0,0,0,0, 1,0,0,0,1,1);
    add(1,0,1,0,7, 1,0,0,1,3,3);
    add(0,0,0,0,0, 1,0,1,2,0,7);
    add(0,0,0,0,0, 1,0,0,0,1,1);
    add(0,1,0,0,0, 1,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,1,0,0);
    // start and stop together in IDLE
    add(1,1,0,0,3, 0,0,0,1,0,0);
    add(0,0,0,0,0, 0,0,0,1,0,0);
    // limit 0 one-shot
    add(1,0,0,0,0, 0,0,0,1,0,0);
    add(0,0,0,0,0, 1,0,0,1,0,7);
    add(0,0,0,0,0, 1,0,1,0,0,0);
    add(0,0,0,0,0, 0,1,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    // Full range auto-reload: wrap 7->0, then stop on a terminal-count cycle
    add(1,0,0,1,7, 0,0,0,0,0,0);
    add(0,0,0,0,0, 1,0,0,0,0,7);
    for (int c = 0; c < 7; c++) add(0,0,0,0,0, 1,0,0,W'(c),up_jk(W'(c)),up_jk(W'(c)));
    add(0,0,0,0,0, 1,0,1,7,0,7);
    for (int c = 0; c < 7; c++) add(0,0,0,0,0, 1,0,0,W'(c),up_jk(W'(c)),up_jk(W'(c)));
    add(0,1,0,0,0, 1,0,0,7,0,0);
    add(0,0,0,0,0, 0,0,0,7,0,0);

    #12;
    chk("reset", 0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      start = tbl[i].start; stop = tbl[i].stop; dir = tbl[i].dir;
      auto_reload = tbl[i].ar; limit = tbl[i].lim;
      #1;
      chk($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].tc,
          tbl[i].cnt, tbl[i].j, tbl[i].k);
    end

    // Async reset between edges while RUN is at count 2
    @(negedge clk); start = 1; dir = 0; auto_reload = 0; limit = 5;
    @(negedge clk); start = 0; limit = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_reset_run", 1,0,0,2,1,1);
    #2 rst = 1'b1;
    #1 chk("reset_mid_run", 0,0,0,0,0,0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_reset%0d", i), 0,0,0,0,0,0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
